dcache_responder: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache that answers the pipeline's MEM-stage load/store requests and stalls the pipeline while it services misses and stores through a request/ready/valid port to backing memory. It replaces the single-cycle data memory in the MEM stage. It is the responder to the core's memory accesses and the initiator toward main memory. Its `stall` output is ORed into the hazard unit's stall.

---
 rtl/dcache_responder_if.sv | 28 ++
 rtl/dcache_responder.sv | 168 ++++++++++++++++
 tb/tb_dcache_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_responder_if.sv
// rtl/dcache_responder_if.sv - core-side load/store port and backing-memory port of the data cache
interface dcache_responder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] WD;
  logic             WE;
  logic             RE;
  logic [WIDTH-1:0] RD;
  logic             stall;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ready;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  A, WD, WE, RE, mem_ready, mem_rvalid, mem_rdata,
    output RD, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output A, WD, WE, RE, mem_ready, mem_rvalid, mem_rdata,
    input  RD, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-through no-write-allocate data cache for the MEM stage
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_responder #(
  parameter int WIDTH = 32,
  parameter int SETS  = 64,
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  dcache_responder_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_LO = IDX_W + OFF_W + 2;
  localparam int TAG_W  = WIDTH - TAG_LO;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic             wait_q, wait_d;
  logic [WIDTH-1:0] base_q, base_d;

  logic             valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS];
  logic [WIDTH-1:0] data_q  [SETS*WORDS];

  logic [WIDTH-1:0] a_word;
  logic [OFF_W-1:0] a_off;
  logic [IDX_W-1:0] a_idx;
  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] base_idx;
  logic [TAG_W-1:0] base_tag;
  logic             is_store, is_load, hit, load_hit;
  logic             line_clr, fill_we, fill_last, store_wr;

  assign a_word   = bus.A & ~WIDTH'(3);
  assign a_off    = a_word[OFF_W+1:2];
  assign a_idx    = a_word[TAG_LO-1:OFF_W+2];
  assign a_tag    = a_word[WIDTH-1:TAG_LO];
  assign base_idx = base_q[TAG_LO-1:OFF_W+2];
  assign base_tag = base_q[WIDTH-1:TAG_LO];

  // A simultaneous WE/RE is a store.
  assign is_store = bus.WE;
  assign is_load  = bus.RE & ~bus.WE;
  assign hit      = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
  assign load_hit = (state_q == S_IDLE) && is_load && hit;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    base_d        = base_q;
    bus.stall     = 1'b0;
    bus.RD        = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    line_clr      = 1'b0;
    fill_we       = 1'b0;
    fill_last     = 1'b0;
    store_wr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_store) begin
          // Stores are offered immediately so a ready memory costs no extra cycle.
          bus.mem_req   = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = a_word;
          bus.mem_wdata = bus.WD;
          bus.stall     = ~bus.mem_ready;
          if (bus.mem_ready) store_wr = hit;
          else               state_d  = S_WRITE;
        end else if (is_load) begin
          if (load_hit) begin
            bus.RD = data_q[{a_idx, a_off}];
          end else begin
            bus.stall = 1'b1;
            base_d    = a_word & ~WIDTH'(WORDS * 4 - 1);
            cnt_d     = '0;
            wait_d    = 1'b0;
            line_clr  = 1'b1;
            state_d   = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        bus.stall = 1'b1;
        if (!wait_q) begin
          bus.mem_req  = 1'b1;
          bus.mem_addr = base_q + WIDTH'({cnt_q, 2'b00});
          if (bus.mem_ready) wait_d = 1'b1;
        end else if (bus.mem_rvalid) begin
          fill_we = 1'b1;
          wait_d  = 1'b0;
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            fill_last = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + OFF_W'(1);
          end
        end
      end
      S_WRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = a_word;
        bus.mem_wdata = bus.WD;
        bus.stall     = ~bus.mem_ready;
        if (bus.mem_ready) begin
          store_wr = hit;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= 1'b0;
      base_q  <= '0;
      for (int i = 0; i < SETS; i++) valid_q[i] <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      base_q  <= base_d;
      // The victim line is invalid for the whole refill so an abort never exposes it.
      if (line_clr) valid_q[a_idx] <= 1'b0;
      if (fill_last) begin
        valid_q[base_idx] <= 1'b1;
        tag_q[base_idx]   <= base_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_we)       data_q[{base_idx, cnt_q}] <= bus.mem_rdata;
      else if (store_wr) data_q[{a_idx, a_off}]    <= bus.WD;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (load_hit) hit_count  <= hit_count + 32'd1;
      if (line_clr) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// tb/tb_dcache_responder.sv - directed table-driven bench for dcache_responder
module tb_dcache_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_responder_if #(.WIDTH(32)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
  dcache_responder dut (.clk(clk), .rst(rst), .bus(bus),
                        .hit_count(hit_count), .miss_count(miss_count));
`else
  dcache_responder dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic        we;
    logic        re;
    int          delay;
    logic [31:0] rd;
    int          stalls;
    int          reads;
    int          writes;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vec [10];
  logic [31:0] mem [logic [31:0]];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hA000_0000 | a;
  endfunction

  task automatic access(input int r);
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        seen = 1'b0;
    logic        done = 1'b0;
    logic [31:0] first = '0;
    logic [31:0] wdat = '0;
    logic [31:0] rd = '0;
    int          stall_n = 0;
    int          nreads = 0;
    int          nwrites = 0;
    bus.A  = vec[r].a;
    bus.WD = vec[r].wd;
    bus.WE = vec[r].we;
    bus.RE = vec[r].re;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      bus.mem_ready  = (cyc >= vec[r].delay);
      bus.mem_rvalid = pend;
      bus.mem_rdata  = pend ? mem_rd(pend_addr) : 32'hBAD0_BAD0;
      pend = 1'b0;
      @(negedge clk);
      if (bus.mem_req && !seen) begin
        seen  = 1'b1;
        first = bus.mem_addr;
      end
      if (bus.mem_req && bus.mem_ready) begin
        if (bus.mem_we) begin
          nwrites++;
          wdat = bus.mem_wdata;
          mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          chk($sformatf("row%0d read_order", r), bus.mem_addr, vec[r].addr + 32'(4 * nreads));
          nreads++;
          pend      = 1'b1;
          pend_addr = bus.mem_addr;
        end
      end
      if (bus.stall) stall_n++;
      else begin
        done = 1'b1;
        rd   = bus.RD;
      end
      @(posedge clk);
      #1;
    end
    chk($sformatf("row%0d completed", r), {31'd0, done}, 32'd1);
    chk($sformatf("row%0d stall_cycles", r), 32'(stall_n), 32'(vec[r].stalls));
    chk($sformatf("row%0d reads", r), 32'(nreads), 32'(vec[r].reads));
    chk($sformatf("row%0d writes", r), 32'(nwrites), 32'(vec[r].writes));
    chk($sformatf("row%0d first_addr", r), first, vec[r].addr);
    if (vec[r].re && !vec[r].we) chk($sformatf("row%0d RD", r), rd, vec[r].rd);
    if (vec[r].writes > 0) chk($sformatf("row%0d wdata", r), wdat, vec[r].wdata);
    bus.WE         = 1'b0;
    bus.RE         = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    int exp_hits = 0;
    int exp_miss = 0;
    //          a             wd            we    re    dly rd            st rd wr addr          wdata
    vec[0] = '{32'h0000_0100, 32'h0,        1'b0, 1'b1, 0, 32'h11,        9, 4, 0, 32'h0000_0100, 32'h0};
    vec[1] = '{32'h0000_0108, 32'h0,        1'b0, 1'b1, 0, 32'h33,        0, 0, 0, 32'h0,         32'h0};
    vec[2] = '{32'h0000_0104, 32'hDEADBEEF, 1'b1, 1'b0, 3, 32'h0,         3, 0, 1, 32'h0000_0104, 32'hDEADBEEF};
    vec[3] = '{32'h0000_0104, 32'h0,        1'b0, 1'b1, 0, 32'hDEADBEEF,  0, 0, 0, 32'h0,         32'h0};
    vec[4] = '{32'h0000_2000, 32'h12345678, 1'b1, 1'b0, 0, 32'h0,         0, 0, 1, 32'h0000_2000, 32'h12345678};
    vec[5] = '{32'h0000_2000, 32'h0,        1'b0, 1'b1, 0, 32'h12345678,  9, 4, 0, 32'h0000_2000, 32'h0};
    vec[6] = '{32'h0000_0500, 32'h0,        1'b0, 1'b1, 0, 32'hA0000500,  9, 4, 0, 32'h0000_0500, 32'h0};
    vec[7] = '{32'h0000_0100, 32'h0,        1'b0, 1'b1, 0, 32'h11,        9, 4, 0, 32'h0000_0100, 32'h0};
    vec[8] = '{32'h0000_0108, 32'hCAFEF00D, 1'b1, 1'b1, 1, 32'h0,         1, 0, 1, 32'h0000_0108, 32'hCAFEF00D};
    vec[9] = '{32'h0000_0108, 32'h0,        1'b0, 1'b1, 0, 32'hCAFEF00D,  0, 0, 0, 32'h0,         32'h0};
    mem[32'h100] = 32'h11;
    mem[32'h104] = 32'h22;
    mem[32'h108] = 32'h33;
    mem[32'h10C] = 32'h44;

    bus.A = '0; bus.WD = '0; bus.WE = 1'b0; bus.RE = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle with ready and a stray rvalid present: nothing may happen.
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("reset stall", {31'd0, bus.stall}, 32'd0);
    chk("reset RD", bus.RD, 32'd0);
    chk("reset mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("reset mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;

    for (int r = 0; r < 10; r++) begin
      access(r);
      if (vec[r].re && !vec[r].we) exp_hits++;
      if (vec[r].reads > 0) exp_miss++;
    end
`ifdef DCACHE_STATS_EN
    chk("table hit_count", hit_count, 32'(exp_hits));
    chk("table miss_count", miss_count, 32'(exp_miss));
`endif

    // Reset while the second refill word is outstanding.
    bus.A = 32'h500; bus.RE = 1'b1; bus.WE = 1'b0; bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("abort detect stall", {31'd0, bus.stall}, 32'd1);
    chk("abort detect mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort word0 addr", bus.mem_addr, 32'h500);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55;
    @(negedge clk);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("abort word1 mem_req", {31'd0, bus.mem_req}, 32'd1);
    chk("abort word1 addr", bus.mem_addr, 32'h504);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.RE = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBADD_A7A0;
    @(negedge clk);
    chk("post-reset mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("post-reset stall", {31'd0, bus.stall}, 32'd0);
    chk("post-reset RD", bus.RD, 32'd0);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b0;
    access(7);
`ifdef DCACHE_STATS_EN
    chk("final hit_count", hit_count, 32'd1);
    chk("final miss_count", miss_count, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
